// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, B-operand selects and RV32 opcode/funct constants
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MULH = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_REM  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_SLTU = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;
  localparam logic [1:0] MX_IMMS = 2'b00;
  localparam logic [1:0] MX_IMMI = 2'b01;
  localparam logic [1:0] MX_RS2  = 2'b10;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
  function automatic logic [3:0] mul_op(input logic [2:0] f3);
    return f3 == 3'b000 ? OP_MUL : f3 == 3'b001 ? OP_MULH : f3 == 3'b100 ? OP_DIV : OP_REM;
  endfunction
  function automatic logic [3:0] br_op(input logic [2:0] f3);
    return f3 == 3'b000 ? OP_BEQ : f3 == 3'b100 ? OP_SLT : OP_SLTU;
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32-entry register file, two read ports with write-through bypass, x0 hardwired to zero
module reg_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] mem [32];
  // write port; x0 never stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end
  // reads forward a same-cycle write so the consumer sees it without waiting
  always_comb begin
    rd1 = ra1 == 5'd0 ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    rd2 = ra2 == 5'd0 ? '0 : (we && wa == ra2) ? wd : mem[ra2];
  end
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32IM decode, operand fetch and scoreboard feeding a registered ALU bundle
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] immS,
  output logic [XLEN-1:0] immI,
  output logic [1:0]      IRMUX,
  output logic [3:0]      op_code,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1_a, rs2_a, d_rd;
  logic [3:0] op, d_op;
  logic [1:0] mx, d_mx;
  logic ok, wr, u1, u2, d_wr, d_u1, d_u2, d_we, shamt, hazard, accept;
  logic [XLEN-1:0] rd1, rd2, d_immi, d_imms;
  logic [31:0] busy, clr, set, live;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rs1_a = instr[19:15];
  assign rs2_a = instr[24:20];
  reg_file #(.XLEN(XLEN)) u_rf (
    .clk(clk), .rst(rst), .ra1(rs1_a), .ra2(rs2_a), .rd1(rd1), .rd2(rd2),
    .we(wb_en), .wa(wb_addr), .wd(wb_data)
  );
  // instruction class decode; illegal encodings are masked off below
  always_comb begin
    op = OP_ILL;
    mx = MX_IMMS;
    ok = 1'b0;
    wr = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    case (opc)
      OPC_OP: begin
        ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) ||
             (f7 == F7_MUL && f3 inside {3'b000, 3'b001, 3'b100, 3'b110});
        op = f7 == F7_MUL ? mul_op(f3) : alu_op(f3, f7 == F7_ALT);
        mx = MX_RS2;
        wr = 1'b1;
        u1 = 1'b1;
        u2 = 1'b1;
      end
      OPC_OPIMM: begin
        ok = f3 == 3'b001 ? f7 == F7_BASE : f3 == 3'b101 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        op = alu_op(f3, f3 == 3'b101 && f7 == F7_ALT);
        mx = MX_IMMI;
        wr = 1'b1;
        u1 = 1'b1;
      end
      OPC_LOAD: begin
        ok = 1'b1;
        op = OP_ADD;
        mx = MX_IMMI;
        wr = 1'b1;
        u1 = 1'b1;
      end
      OPC_STORE: begin
        ok = 1'b1;
        op = OP_ADD;
        u1 = 1'b1;
        u2 = 1'b1;
      end
      OPC_BRANCH: begin
        ok = f3 inside {3'b000, 3'b100, 3'b110};
        op = br_op(f3);
        mx = MX_RS2;
        u1 = 1'b1;
        u2 = 1'b1;
      end
      default: ;
    endcase
  end
  assign d_op   = ok ? op : OP_ILL;
  assign d_mx   = ok ? mx : MX_IMMS;
  assign d_wr   = ok & wr;
  assign d_u1   = ok & u1;
  assign d_u2   = ok & u2;
  assign d_rd   = d_wr ? instr[11:7] : 5'd0;
  assign d_we   = d_wr && d_rd != 5'd0;
  assign shamt  = opc == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101);
  assign d_immi = shamt ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
  assign d_imms = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  // a writeback this cycle releases its register immediately, so it does not stall
  assign clr    = wb_en ? 32'd1 << wb_addr : 32'd0;
  assign live   = busy & ~clr;
  assign hazard = (d_u1 & live[rs1_a]) | (d_u2 & live[rs2_a]) | (d_we & live[d_rd]);
  assign in_ready = !hazard && !(out_valid && !out_ready);
  assign accept = in_valid && in_ready;
  assign set    = (accept && d_we) ? 32'd1 << d_rd : 32'd0;
  // scoreboard and output bundle; a new destination claim beats a same-cycle release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      out_valid <= 1'b0;
      A         <= '0;
      rs2       <= '0;
      immS      <= '0;
      immI      <= '0;
      IRMUX     <= '0;
      op_code   <= '0;
      rd_addr   <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      busy <= live | set;
      if (accept) begin
        out_valid <= 1'b1;
        A         <= rd1;
        rs2       <= rd2;
        immS      <= d_imms;
        immI      <= d_immi;
        IRMUX     <= d_mx;
        op_code   <= d_op;
        rd_addr   <= d_rd;
        rd_we     <= d_we;
        illegal   <= !ok;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed and randomized checks of the decode stage against a behavioural model
module tb_alu_decode_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, wb_data = '0;
  logic [4:0] wb_addr = '0;
  logic in_ready, out_valid, rd_we, illegal;
  logic [31:0] A, rs2, immS, immI;
  logic [1:0] IRMUX;
  logic [3:0] op_code;
  logic [4:0] rd_addr;
  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .rs2(rs2), .immS(immS), .immI(immI), .IRMUX(IRMUX),
    .op_code(op_code), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  localparam logic [31:0] F3_OPS = {4'h6, 4'h7, 4'hA, 4'h8, 4'hD, 4'hC, 4'h9, 4'h0};
  localparam logic [31:0] M_OPS  = {4'h0, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2, 4'h3};
  localparam logic [31:0] B_OPS  = {4'h0, 4'hD, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'hE};
  localparam logic [7:0]  M_OK   = 8'b0101_0011;
  localparam logic [7:0]  B_OK   = 8'b0101_0001;
  typedef struct packed {
    logic [3:0] op; logic [1:0] mx; logic [31:0] ii; logic [31:0] is;
    logic [4:0] rd; logic we; logic ill; logic u1; logic u2;
  } dec_t;
  logic [31:0] m_regs [32];
  logic m_busy [32];
  logic m_valid;
  dec_t m_d;
  logic [31:0] m_a, m_b;
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic legal, wr;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    legal = 1'b0; wr = 1'b0; d = '0;
    d.ii = {{20{w[31]}}, w[31:20]};
    d.is = {{20{w[31]}}, w[31:25], w[11:7]};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin legal = 1'b1; d.op = F3_OPS[{f3, 2'b00} +: 4]; end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1'b1; d.op = F3_OPS[{f3, 2'b00} +: 4] + 4'd1; end
      else if (f7 == 7'h01 && M_OK[f3]) begin legal = 1'b1; d.op = M_OPS[{f3, 2'b00} +: 4]; end
      d.mx = 2'd2; wr = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) d.ii = {27'd0, w[24:20]};
      legal = (f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      d.op = F3_OPS[{f3, 2'b00} +: 4] + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd1 : 4'd0);
      d.mx = 2'd1; wr = 1'b1; d.u1 = 1'b1;
    end else if (opc == 7'h03) begin
      legal = 1'b1; d.op = 4'h0; d.mx = 2'd1; wr = 1'b1; d.u1 = 1'b1;
    end else if (opc == 7'h23) begin
      legal = 1'b1; d.op = 4'h0; d.mx = 2'd0; d.u1 = 1'b1; d.u2 = 1'b1;
    end else if (opc == 7'h63) begin
      legal = B_OK[f3]; d.op = B_OPS[{f3, 2'b00} +: 4]; d.mx = 2'd2; d.u1 = 1'b1; d.u2 = 1'b1;
    end
    if (!legal) begin d.op = 4'hF; d.mx = 2'd0; wr = 1'b0; d.u1 = 1'b0; d.u2 = 1'b0; end
    d.ill = !legal;
    d.rd = wr ? w[11:7] : 5'd0;
    d.we = wr && d.rd != 5'd0;
    return d;
  endfunction
  function automatic logic [31:0] rd_val(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return a == 5'd0 ? 32'd0 : (we && wa == a) ? wd : m_regs[a];
  endfunction
  function automatic logic is_live(input logic [4:0] a, input logic we, input logic [4:0] wa);
    return a != 5'd0 && m_busy[a] && !(we && wa == a);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_valid = 1'b0;
  endtask
  task automatic step(input logic v, input logic [31:0] w, input logic orr, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dec_t d;
    logic rdy, acc;
    in_valid = v; instr = w; out_ready = orr; wb_en = we; wb_addr = wa; wb_data = wd;
    d = ref_dec(w);
    rdy = !((d.u1 && is_live(w[19:15], we, wa)) || (d.u2 && is_live(w[24:20], we, wa)) ||
            (d.we && is_live(d.rd, we, wa))) && !(m_valid && !orr);
    #1 check("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (acc) begin
      m_d = d;
      m_a = rd_val(w[19:15], we, wa, wd);
      m_b = rd_val(w[24:20], we, wa, wd);
      m_valid = 1'b1;
    end else if (orr) m_valid = 1'b0;
    if (we) m_busy[wa] = 1'b0;
    if (we && wa != 5'd0) m_regs[wa] = wd;
    if (acc && d.we) m_busy[d.rd] = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("op_code", op_code, m_d.op);
      check("IRMUX", IRMUX, m_d.mx);
      check("A", A, m_a);
      check("rs2", rs2, m_b);
      check("immI", immI, m_d.ii);
      check("immS", immS, m_d.is);
      check("rd_addr", rd_addr, m_d.rd);
      check("rd_we", rd_we, m_d.we);
      check("illegal", illegal, m_d.ill);
    end
  endtask
  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0: return 7'h00;
      1: return 7'h20;
      2: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction
  function automatic logic [31:0] gen();
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    f3 = 3'($urandom);
    case ($urandom_range(0, 5))
      0: return {pick_f7(), r2, r1, f3, rd, 7'h33};
      1: return {pick_f7(), r2, r1, f3, rd, 7'h13};
      2: return {12'($urandom), r1, f3, rd, 7'h03};
      3: return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h23};
      4: return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
      default: return $urandom;
    endcase
  endfunction
  logic [31:0] s_a, s_i;
  logic [3:0] s_op;
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_A", A, 0);
    check("rst_op", op_code, 0);
    check("rst_rd_we", rd_we, 0);
    rst = 1'b0;
    step(1, 32'h00500093, 1, 0, 0, 0);
    check("addi_op", op_code, 4'h0);
    check("addi_mux", IRMUX, 2'b01);
    check("addi_immI", immI, 5);
    check("addi_A", A, 0);
    check("addi_rd", rd_addr, 1);
    check("addi_we", rd_we, 1);
    step(1, 32'h00108133, 1, 0, 0, 0);
    check("add_stalled_valid", out_valid, 0);
    step(1, 32'h00108133, 1, 1, 1, 5);
    check("add_bypass_A", A, 5);
    check("add_bypass_rs2", rs2, 5);
    step(1, 32'hFE312E23, 1, 1, 2, 10);
    check("sw_op", op_code, 4'h0);
    check("sw_mux", IRMUX, 2'b00);
    check("sw_immS", immS, 32'hFFFFFFFC);
    check("sw_we", rd_we, 0);
    step(1, 32'h40325213, 1, 0, 0, 0);
    check("srai_op", op_code, 4'hB);
    check("srai_immI", immI, 3);
    step(1, 32'h0262A3B3, 1, 0, 0, 0);
    check("ill_flag", illegal, 1);
    check("ill_op", op_code, 4'hF);
    check("ill_we", rd_we, 0);
    step(1, 32'h00100493, 1, 0, 0, 0);
    s_a = A; s_i = immI; s_op = op_code;
    check("hold_rd", rd_addr, 9);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00100513, 0, 0, 0, 0);
      check("hold_valid", out_valid, 1);
      check("hold_A", A, s_a);
      check("hold_immI", immI, s_i);
      check("hold_op", op_code, s_op);
      check("hold_rd_addr", rd_addr, 9);
      check("hold_in_ready", in_ready, 0);
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_rd_we", rd_we, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 32'h00448533, 1, 0, 0, 0);
    check("postrst_valid", out_valid, 1);
    check("postrst_A", A, 0);
    for (int n = 0; n < 1500; n++) begin
      int q[$];
      logic we;
      logic [4:0] wa;
      for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
      we = 1'b0; wa = 5'd0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1; wa = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1'b1; wa = 5'($urandom);
      end
      step($urandom_range(0, 4) != 0, gen(), $urandom_range(0, 3) != 0, we, wa, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock, rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream instruction valid.
REQ-005 Port: in_ready  output  1  stage accepts instr this cycle.
REQ-006 Port: instr  input  32  RV32IM-format instruction word.
REQ-007 Port: wb_en  input  1  writeback strobe from the ALU consumer.
REQ-008 Port: wb_addr  input  5  writeback destination register.
REQ-009 Port: wb_data  input  32  writeback value.
REQ-010 Port: out_valid  output  1  ALU operand bundle valid.
REQ-011 Port: out_ready  input  1  ALU side accepts bundle.
REQ-012 Port: A  output  32  rs1 value (RS1 to ALU).
REQ-013 Port: rs2  output  32  rs2 value.
REQ-014 Port: immS  output  32  sign-extended {instr[31:25],instr[11:7]}.
REQ-015 Port: immI  output  32  sign-extended instr[31:20]; zero-extended instr[24:20] for shift-immediates.
REQ-016 Port: IRMUX  output  2  B select: 00 immS, 01 immI, 10 rs2.
REQ-017 Port: op_code  output  4  ALU operation code.
REQ-018 Port: rd_addr  output  5  destination register of the bundle.
REQ-019 Port: rd_we  output  1  bundle writes rd_addr (0 if rd_addr==0).
REQ-020 Port: illegal  output  1  undecodable instruction flag.

Function
REQ-021 op_code map SHALL be: ADD 0000, SUB 0001, MULH 0010, MUL 0011, DIV 0100, REM 0101, AND 0110, OR 0111, XOR 1000, SLL 1001, SRL 1010, SRA 1011, SLT/BLT 1100, SLTU/BLTU 1101, BEQ 1110, illegal 1111.
REQ-022 Opcode 0110011 SHALL decode funct7 0000000/0100000 (SUB, SRA) and 0000001 (MUL, MULH, DIV, REM) via funct3 with IRMUX=10, rd_we set; other funct7/funct3 combos are illegal.
REQ-023 Opcode 0010011 SHALL decode the same funct3 table with IRMUX=01; load 0000011 -> ADD/01/rd_we; store 0100011 -> ADD/00/no rd; branch 1100011 funct3 000/100/110 -> BEQ/BLT/BLTU, IRMUX=10, no rd.
REQ-024 Illegal instructions SHALL emit op_code 1111, illegal=1, rd_we=0, and SHALL NOT touch the scoreboard.
REQ-025 Register file: 32x32, x0 reads 0 and ignores writes; wb_en writes wb_data at clk edge.
REQ-026 Read bypass: if wb_en and wb_addr equals a nonzero source in the same cycle, wb_data SHALL be used.
REQ-027 Scoreboard busy[31:1]: set on accepted instruction with rd_we; cleared on wb_en for wb_addr; simultaneous set and clear of same index -> set wins.
REQ-028 Stall (in_ready=0) when a used source or rd is busy and not cleared by wb this cycle, or when out_valid=1 and out_ready=0.
REQ-029 Latency: accepted instruction appears on outputs with out_valid=1 the next cycle; one bundle per cycle at full throughput.
REQ-030 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-031 out_valid SHALL deassert after handshake if no new instruction is accepted.

Reset
REQ-032 rst SHALL asynchronously clear out_valid, busy[], all register-file entries, and all output registers to 0; in_ready=1 when out_valid=0 and no hazard.
REQ-033 A reset mid-stall SHALL discard the held bundle; no writeback is expected for it.

Structure
REQ-034 op_code constants, IRMUX constants and RV32 opcode/funct constants belong in shared package alu_pkg.
REQ-035 Sub-module reg_file (2 read, 1 write, async reset, bypass) is natural; decode and scoreboard stay in the top.

Verification
REQ-036 After reset, issue ADDI x1,x0,5 -> next cycle op_code 0000, IRMUX 01, immI 5, A 0, rd_addr 1, rd_we 1.
REQ-037 Issue ADD x2,x1,x1 before x1 writeback -> in_ready 0 until wb_en(1,5); same cycle bypass gives A=rs2=5.
REQ-038 Store SW x3,-4(x2) -> op_code 0000, IRMUX 00, immS 0xFFFFFFFC, rd_we 0, no busy bit set.
REQ-039 SRAI x4,x4,3 -> op_code 1011, immI 3; funct7 0000001 funct3 010 in 0110011 -> illegal 1, op 1111.
REQ-040 Hold out_ready=0 for 3 cycles with bundle valid -> outputs stable, in_ready 0; assert rst mid-stall -> out_valid 0, busy cleared.
